// File: rtl/rfid_frame_pkg.sv
// Shared types, constants and the CRC byte step for the RFID frame engine.
// Build option: define FRAME_CRC8_EN for CRC-8 (poly 0x07); otherwise a plain XOR checksum is used.
package rfid_frame_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CRC,
    S_DISPATCH,
    S_WAIT_RSP,
    S_TX_MAGIC,
    S_TX_STATUS,
    S_TX_CRC
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam logic [7:0] CMD_CHECK_UID = 8'h10;
  localparam logic [7:0] CMD_ADD_UID   = 8'h11;
  localparam logic [7:0] ST_CRC_ERR    = 8'hFE;
  localparam logic [7:0] ST_LEN_ERR    = 8'hFD;

  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
`ifdef FRAME_CRC8_EN
    // MSB-first, no reflection, no final XOR
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
`endif
    return c;
  endfunction

endpackage

// File: rtl/rfid_crc8.sv
// Combinational one-byte CRC update shared by the rx checker and the tx reply.
// Algorithm selected by FRAME_CRC8_EN (CRC-8 poly 0x07) or XOR when undefined.
module rfid_crc8
  import rfid_frame_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  assign crc_out = crc_step(crc_in, data);

endmodule

// File: rtl/rfid_frame_engine.sv
// Byte-stream frame parser MAGIC|CMD|LEN|PAYLOAD|CRC with LUT dispatch and MAGIC|STATUS|CRC reply.
// Build option: FRAME_CRC8_EN selects CRC-8 instead of the XOR checksum (see rfid_frame_pkg).
module rfid_frame_engine
  import rfid_frame_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         LEN_W          = 8,
  parameter logic [7:0] MAGIC          = MAGIC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               cmd_code,
  output logic [LEN_W-1:0]         cmd_len,
  output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
  input  logic                     rsp_valid,
  input  logic [7:0]               rsp_status,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [7:0]               tx_data,
  output logic                     busy,
  output logic [CNT_W-1:0]         err_crc_cnt,
  output logic [CNT_W-1:0]         err_timeout_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state;
  logic [7:0]       crc_acc;
  logic [7:0]       crc_rx;
  logic [7:0]       crc_tx;
  logic [7:0]       status;
  logic [LEN_W-1:0] byte_cnt;
  logic             ovf;
  logic [TMR_W-1:0] timer;
  logic             rx_phase;

  rfid_crc8 u_crc_rx (.crc_in(crc_acc), .data(rx_data), .crc_out(crc_rx));
  rfid_crc8 u_crc_tx (.crc_in(8'h00),   .data(status),  .crc_out(crc_tx));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign rx_phase = (state == S_CMD) || (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CRC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      crc_acc         <= '0;
      cmd_code        <= '0;
      cmd_len         <= '0;
      cmd_payload     <= '0;
      byte_cnt        <= '0;
      ovf             <= 1'b0;
      status          <= '0;
      timer           <= '0;
      err_crc_cnt     <= '0;
      err_timeout_cnt <= '0;
      cmd_valid       <= 1'b0;
      tx_valid        <= 1'b0;
      tx_data         <= '0;
      busy            <= 1'b0;
    end else begin
      timer <= (rx_phase && !rx_valid) ? timer + 1'b1 : '0;

      // an in-progress frame with a silent line is dropped without a reply
      if (rx_phase && !rx_valid && timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
        state           <= S_IDLE;
        busy            <= 1'b0;
        err_timeout_cnt <= sat_inc(err_timeout_cnt);
      end else begin
        case (state)
          S_IDLE: if (rx_valid && rx_data == MAGIC) begin
            state   <= S_CMD;
            crc_acc <= '0;
            busy    <= 1'b1;
          end
          S_CMD: if (rx_valid) begin
            cmd_code <= rx_data;
            crc_acc  <= crc_rx;
            state    <= S_LEN;
          end
          S_LEN: if (rx_valid) begin
            cmd_len  <= LEN_W'(rx_data);
            crc_acc  <= crc_rx;
            byte_cnt <= '0;
            ovf      <= (32'(rx_data) > 32'(MAX_PAYLOAD));
            state    <= (rx_data == 8'h00) ? S_CRC : S_PAYLOAD;
          end
          S_PAYLOAD: if (rx_valid) begin
            for (int k = 0; k < MAX_PAYLOAD; k++) begin
              if (32'(byte_cnt) == 32'(k)) cmd_payload[k*8 +: 8] <= rx_data;
            end
            crc_acc  <= crc_rx;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == cmd_len - 1'b1) state <= S_CRC;
          end
          // folding the received check byte into a matching accumulator yields zero
          S_CRC: if (rx_valid) begin
            if (crc_rx != 8'h00) begin
              status      <= ST_CRC_ERR;
              err_crc_cnt <= sat_inc(err_crc_cnt);
              state       <= S_TX_MAGIC;
              tx_valid    <= 1'b1;
              tx_data     <= MAGIC;
            end else if (ovf) begin
              status   <= ST_LEN_ERR;
              state    <= S_TX_MAGIC;
              tx_valid <= 1'b1;
              tx_data  <= MAGIC;
            end else begin
              state     <= S_DISPATCH;
              cmd_valid <= 1'b1;
            end
          end
          S_DISPATCH: if (cmd_ready) begin
            state     <= S_WAIT_RSP;
            cmd_valid <= 1'b0;
          end
          S_WAIT_RSP: if (rsp_valid) begin
            status   <= rsp_status;
            state    <= S_TX_MAGIC;
            tx_valid <= 1'b1;
            tx_data  <= MAGIC;
          end
          S_TX_MAGIC: if (tx_ready) begin
            state   <= S_TX_STATUS;
            tx_data <= status;
          end
          S_TX_STATUS: if (tx_ready) begin
            state   <= S_TX_CRC;
            tx_data <= crc_tx;
          end
          S_TX_CRC: if (tx_ready) begin
            state    <= S_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rfid_frame_engine.sv
// Self-checking bench for rfid_frame_engine: vector table plus scoreboard queues for
// command handshakes and reply bytes, and hand-written timeout / back-pressure / reset sequences.
module tb_rfid_frame_engine;

  localparam int         MAXP = 16;
  localparam int         LW   = 8;
  localparam int         TMO  = 64;
  localparam int         CW   = 16;
  localparam logic [7:0] MG   = 8'hA5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              cmd_valid;
  logic              cmd_ready = 1'b1;
  logic [7:0]        cmd_code;
  logic [LW-1:0]     cmd_len;
  logic [8*MAXP-1:0] cmd_payload;
  logic              rsp_valid = 1'b0;
  logic [7:0]        rsp_status = 8'h00;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic [7:0]        tx_data;
  logic              busy;
  logic [CW-1:0]     err_crc_cnt;
  logic [CW-1:0]     err_timeout_cnt;

  always #5 clk = ~clk;

  rfid_frame_engine #(
    .MAX_PAYLOAD(MAXP), .LEN_W(LW), .MAGIC(MG), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_len(cmd_len), .cmd_payload(cmd_payload), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .busy(busy), .err_crc_cnt(err_crc_cnt),
    .err_timeout_cnt(err_timeout_cnt)
  );

  typedef struct {
    logic [7:0]  cmd;
    int          len;
    logic [31:0] p;
    bit          bad;
    logic [7:0]  rsp;
  } vec_t;

  typedef struct {
    logic [7:0]  code;
    int          len;
    logic [31:0] data;
    logic [31:0] mask;
  } cmd_exp_t;

  logic [7:0] exp_tx[$];
  cmd_exp_t   exp_cmd[$];
  cmd_exp_t   ce_m;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cmd_seen = 0;
  int         seen0 = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mcrc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
`ifdef FRAME_CRC8_EN
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
`endif
    return r;
  endfunction

  function automatic logic [7:0] pb(input vec_t v, input int k);
    return (k < 4) ? v.p[8*k +: 8] : 8'(k);
  endfunction

  // scoreboard: pop expectations whenever a handshake is about to complete
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
      end else check("tx_byte", tx_data, exp_tx.pop_front());
    end
    if (!rst && cmd_valid && cmd_ready) begin
      cmd_seen++;
      if (exp_cmd.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL cmd_unexpected: got code %0h expected no command", cmd_code);
      end else begin
        ce_m = exp_cmd.pop_front();
        check("cmd_code", cmd_code, ce_m.code);
        check("cmd_len", cmd_len, ce_m.len);
        check("cmd_payload", cmd_payload[31:0] & ce_m.mask, ce_m.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_rsp(input logic [7:0] s);
    rsp_valid = 1'b1; rsp_status = s;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cmd(input int target);
    for (int i = 0; i < 100; i++) begin
      if (cmd_seen >= target) break;
      @(posedge clk); #1;
    end
    check("cmd_handshake", cmd_seen >= target, 1);
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check("return_idle", busy, 0);
  endtask

  task automatic prep_send(input vec_t v, output bit disp);
    logic [7:0] c, st;
    cmd_exp_t   ce;
    c = mcrc(8'h00, v.cmd);
    c = mcrc(c, 8'(v.len));
    for (int k = 0; k < v.len; k++) c = mcrc(c, pb(v, k));
    disp = !v.bad && (v.len <= MAXP);
    st = v.bad ? 8'hFE : ((v.len > MAXP) ? 8'hFD : v.rsp);
    exp_tx.push_back(MG);
    exp_tx.push_back(st);
    exp_tx.push_back(mcrc(8'h00, st));
    if (disp) begin
      ce.code = v.cmd; ce.len = v.len; ce.mask = '0;
      for (int k = 0; k < 4; k++) if (k < v.len) ce.mask[8*k +: 8] = 8'hFF;
      ce.data = v.p & ce.mask;
      exp_cmd.push_back(ce);
    end
    seen0 = cmd_seen;
    send_byte(MG);
    send_byte(v.cmd);
    send_byte(8'(v.len));
    for (int k = 0; k < v.len; k++) send_byte(pb(v, k));
    send_byte(v.bad ? (c ^ 8'h3C) : c);
  endtask

  task automatic finish_frame(input vec_t v, input bit disp);
    if (disp) begin
      check("cmd_latency", cmd_valid, 1);
      wait_cmd(seen0 + 1);
      do_rsp(v.rsp);
      check("tx_latency", tx_valid, 1);
    end else check("no_dispatch", cmd_valid, 0);
    wait_idle(200);
    check("tx_drained", exp_tx.size(), 0);
    check("cmd_count", cmd_seen - seen0, disp);
  endtask

  task automatic run_vec(input vec_t v);
    bit d;
    prep_send(v, d);
    finish_frame(v, d);
  endtask

  vec_t vecs[7];
  vec_t vb, vr;
  bit   d;

  initial begin
    vecs[0] = '{8'h10, 0,        32'h00000000, 1'b0, 8'h01};
    vecs[1] = '{8'h11, 3,        32'h00332211, 1'b0, 8'h00};
    vecs[2] = '{8'h10, 0,        32'h00000000, 1'b1, 8'h00};
    vecs[3] = '{8'h11, MAXP + 1, 32'h44332211, 1'b0, 8'h00};
    vecs[4] = '{8'h11, MAXP,     32'hDDCCBBAA, 1'b0, 8'h5A};
    vecs[5] = '{8'h10, 1,        32'h000000FF, 1'b0, 8'h7E};
    vecs[6] = '{8'h11, 2,        32'h00009988, 1'b1, 8'h00};

    step(3);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_code", cmd_code, 0);
    check("rst_cmd_len", cmd_len, 0);
    check("rst_payload", cmd_payload, 0);
    check("rst_err_crc", err_crc_cnt, 0);
    check("rst_err_tmo", err_timeout_cnt, 0);
    rst = 1'b0;
    step(1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    check("err_crc_total", err_crc_cnt, 2);
    check("err_tmo_none", err_timeout_cnt, 0);

    // command held under back-pressure; a stray MAGIC must not restart parsing
    vb = '{8'h11, 3, 32'h00332211, 1'b0, 8'h42};
    cmd_ready = 1'b0;
    prep_send(vb, d);
    for (int i = 0; i < 20; i++) begin
      check("hold_valid", cmd_valid, 1);
      check("hold_code", cmd_code, 8'h11);
      check("hold_len", cmd_len, 3);
      check("hold_payload", cmd_payload[23:0], 24'h332211);
      if (i == 10) send_byte(MG);
      else step(1);
    end
    cmd_ready = 1'b1;
    finish_frame(vb, d);

    // idle noise, then an abandoned frame
    send_byte(8'h00);
    send_byte(8'h33);
    check("idle_ignore", busy, 0);
    send_byte(MG);
    send_byte(8'h10);
    step(TMO - 1);
    check("pre_timeout_busy", busy, 1);
    step(2);
    check("timeout_idle", busy, 0);
    check("timeout_cnt", err_timeout_cnt, 1);
    check("timeout_no_tx", tx_valid, 0);
    run_vec(vecs[0]);

    // slow transmitter, then reset in the middle of the reply
    vr = '{8'h10, 0, 32'h00000000, 1'b0, 8'h3C};
    prep_send(vr, d);
    wait_cmd(seen0 + 1);
    tx_ready = 1'b0;
    do_rsp(8'h3C);
    for (int i = 0; i < 5; i++) begin
      check("hold_tx_valid", tx_valid, 1);
      check("hold_tx_magic", tx_data, MG);
      step(1);
    end
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_tx_status", tx_data, 8'h3C);
      step(1);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_mid_tx_valid", tx_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_err_crc", err_crc_cnt, 0);
    check("rst_mid_tx_data", tx_data, 0);
    exp_tx.delete();
    tx_ready = 1'b1;
    step(2);
    check("post_rst_no_tx", tx_valid, 0);
    run_vec(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
